fft_result_display: RTL

Output sequencer for the FFT butterfly datapath and the counterpart of the switch-driven operand loader. It captures one butterfly result (Rey, Imy, Rez, Imz) when the datapath signals it is ready. It then presents the four words one at a time on a single n-bit display bus, advancing on a user step button. After the last word it pulses `done` so the operand loader can return to loading the next b/a pair.

---
 rtl/fft_result_display.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fft_result_display.sv
// Output sequencer for one FFT butterfly result: captures Rey/Imy/Rez/Imz and shows them in turn on disp.
// Optional timed auto-advance is enabled by defining FFT_RESULT_DISPLAY_AUTO_ADVANCE_EN.
module fft_result_display #(
  parameter int n     = 8,
  parameter int DWELL = 16
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic         ReadyIn,
  input  logic [n-1:0] Rey,
  input  logic [n-1:0] Imy,
  input  logic [n-1:0] Rez,
  input  logic [n-1:0] Imz,
  input  logic         step,
  output logic [n-1:0] disp,
  output logic [1:0]   field,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHOW_REY = 3'd1,
    SHOW_IMY = 3'd2,
    SHOW_REZ = 3'd3,
    SHOW_IMZ = 3'd4
  } state_t;

  if (DWELL < 2) begin : g_dwell_check
    $error("fft_result_display: DWELL must be at least 2");
  end

  state_t       state_r, state_s;
  logic         step_q_r;
  logic         step_ev_s;
  logic         advance_s;
  logic         cap_s;
  logic [n-1:0] rey_r, imy_r, rez_r, imz_r;
  logic [n-1:0] rey_s, imy_s, rez_s, imz_s;
  logic [n-1:0] disp_r, disp_s;
  logic [1:0]   field_r, field_s;
  logic         busy_r, busy_s;
  logic         done_r, done_s;
  logic         overrun_r, overrun_s;

  function automatic logic [n-1:0] word_sel(input state_t st, input logic [n-1:0] w0,
                                             input logic [n-1:0] w1, input logic [n-1:0] w2,
                                             input logic [n-1:0] w3);
    case (st)
      SHOW_REY: word_sel = w0;
      SHOW_IMY: word_sel = w1;
      SHOW_REZ: word_sel = w2;
      SHOW_IMZ: word_sel = w3;
      default:  word_sel = {n{1'b0}};
    endcase
  endfunction

  function automatic logic [1:0] field_sel(input state_t st);
    case (st)
      SHOW_REY: field_sel = 2'd0;
      SHOW_IMY: field_sel = 2'd1;
      SHOW_REZ: field_sel = 2'd2;
      SHOW_IMZ: field_sel = 2'd3;
      default:  field_sel = 2'd0;
    endcase
  endfunction

  assign step_ev_s = step & ~step_q_r;

`ifdef FFT_RESULT_DISPLAY_AUTO_ADVANCE_EN
  localparam int CW = $clog2(DWELL);
  logic [CW-1:0] dwell_r;

  assign advance_s = step_ev_s | (dwell_r == CW'(DWELL - 1));

  // Dwell counter: restarts whenever a SHOW state is entered, counts while it is held.
  always_ff @(posedge clk) begin
    if (Rst) begin
      dwell_r <= {CW{1'b0}};
    end else if ((state_s != state_r) || (state_r == IDLE)) begin
      dwell_r <= {CW{1'b0}};
    end else begin
      dwell_r <= dwell_r + CW'(1);
    end
  end
`else
  assign advance_s = step_ev_s;
`endif

  // Next-state, capture and next-output logic; outputs follow the next state so they can be registered.
  always_comb begin
    state_s   = state_r;
    cap_s     = 1'b0;
    done_s    = 1'b0;
    overrun_s = overrun_r;
    case (state_r)
      IDLE: begin
        if (ReadyIn) begin
          cap_s   = 1'b1;
          state_s = SHOW_REY;
        end else begin
          state_s = IDLE;
        end
      end
      SHOW_REY: begin
        if (advance_s) state_s = SHOW_IMY;
        else           state_s = SHOW_REY;
      end
      SHOW_IMY: begin
        if (advance_s) state_s = SHOW_REZ;
        else           state_s = SHOW_IMY;
      end
      SHOW_REZ: begin
        if (advance_s) state_s = SHOW_IMZ;
        else           state_s = SHOW_REZ;
      end
      SHOW_IMZ: begin
        if (advance_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = SHOW_IMZ;
        end
      end
      default: state_s = IDLE;
    endcase

    // A result offered while a display sequence is in progress is lost.
    if (ReadyIn && (state_r != IDLE)) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = overrun_r;
    end

    if (cap_s) begin
      rey_s = Rey;
      imy_s = Imy;
      rez_s = Rez;
      imz_s = Imz;
    end else begin
      rey_s = rey_r;
      imy_s = imy_r;
      rez_s = rez_r;
      imz_s = imz_r;
    end

    disp_s  = word_sel(state_s, rey_s, imy_s, rez_s, imz_s);
    field_s = field_sel(state_s);
    busy_s  = (state_s != IDLE);
  end

  // State, capture, edge-detect and output registers.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_r   <= IDLE;
      step_q_r  <= 1'b0;
      rey_r     <= {n{1'b0}};
      imy_r     <= {n{1'b0}};
      rez_r     <= {n{1'b0}};
      imz_r     <= {n{1'b0}};
      disp_r    <= {n{1'b0}};
      field_r   <= 2'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      step_q_r  <= step;
      rey_r     <= rey_s;
      imy_r     <= imy_s;
      rez_r     <= rez_s;
      imz_r     <= imz_s;
      disp_r    <= disp_s;
      field_r   <= field_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      overrun_r <= overrun_s;
    end
  end

  assign disp    = disp_r;
  assign field   = field_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign overrun = overrun_r;

endmodule
